// File: rtl/multicycle_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the RV32I-subset multi-cycle control path:
//   - major opcode constants and the funct7 values the decoder recognises
//   - alu_op_e      : ALU operation encoding driven to the datapath
//   - ctrl_state_e  : sequencer states
//   - pc_src / wb_sel mux encodings
//   - funct3_alu_op : funct3/funct7 -> ALU operation for R-type and I-ALU
// ---------------------------------------------------------------------------
package processor_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_e;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    // R-type and I-ALU share one funct3 table. The only difference is that
    // an immediate add has no subtract form, so funct7 may only select SUB
    // when the second operand is a register.
    function automatic alu_op_e funct3_alu_op(input logic [2:0] f3,
                                              input logic [6:0] f7,
                                              input logic       is_reg);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_reg && (f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
// Bundle between the control sequencer and the datapath/memory side.
//   Instruction fields : opcode, funct3, funct7   (from the IR)
//   Status             : alu_zero, mem_ready
//   Memory controls    : mem_req, mem_we, mem_addr_sel
//   Datapath controls  : ir_write, pc_write, pc_src, reg_write, alu_src_b,
//                        alu_operation, wb_sel
//   Status outputs     : instr_done, illegal_instr
//   Counters           : cycle_count, instret_count (CNT_WIDTH bits)
// Modports:
//   master : the control FSM (drives controls, reads IR fields/status)
//   slave  : the datapath side (drives IR fields/status, reads controls)
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if #(
    parameter int CNT_WIDTH = 32
);
    import processor_pkg::*;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 alu_zero;
    logic                 mem_ready;

    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_addr_sel;
    logic                 ir_write;
    logic                 pc_write;
    logic [1:0]           pc_src;
    logic                 reg_write;
    logic                 alu_src_b;
    alu_op_e              alu_operation;
    logic [1:0]           wb_sel;
    logic                 instr_done;
    logic                 illegal_instr;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] instret_count;

    modport master (
        input  opcode, funct3, funct7, alu_zero, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               reg_write, alu_src_b, alu_operation, wb_sel, instr_done,
               illegal_instr, cycle_count, instret_count
    );

    modport slave (
        output opcode, funct3, funct7, alu_zero, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
               reg_write, alu_src_b, alu_operation, wb_sel, instr_done,
               illegal_instr, cycle_count, instret_count
    );

endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Purely combinational instruction decode for the control FSM.
//   opcode_i, funct3_i, funct7_i : instruction fields from the IR
//   alu_op_o                     : ALU operation for this instruction
//   illegal_o                    : encoding is outside the supported subset
// ---------------------------------------------------------------------------
module alu_decoder
    import processor_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output alu_op_e    alu_op_o,
    output logic       illegal_o
);

    // Per-opcode ALU selection and legality. Only R-type constrains funct7;
    // I-ALU shifts read funct7[5] but any other funct7 bits are accepted.
    always_comb begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_RTYPE: begin
                alu_op_o = funct3_alu_op(funct3_i, funct7_i, 1'b1);
                if ((funct7_i != F7_BASE) && (funct7_i != F7_ALT)) begin
                    illegal_o = 1'b1;
                end else if ((funct7_i == F7_ALT) &&
                             (funct3_i != 3'b000) && (funct3_i != 3'b101)) begin
                    illegal_o = 1'b1;
                end
            end
            OPC_IALU: begin
                alu_op_o = funct3_alu_op(funct3_i, funct7_i, 1'b0);
            end
            OPC_LUI: begin
                alu_op_o = ALU_PASSB;
            end
            OPC_LOAD, OPC_STORE: begin
                alu_op_o  = ALU_ADD;
                illegal_o = (funct3_i != F3_WORD);
            end
            OPC_BRANCH: begin
                // Only BEQ/BNE exist, i.e. funct3 must be 00x.
                alu_op_o  = ALU_SUB;
                illegal_o = (funct3_i[2:1] != 2'b00);
            end
            OPC_JAL: begin
                alu_op_o = ALU_ADD;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Multi-cycle sequencer for the RV32I-subset datapath. Steps the shared
// ALU, register file, PC and single memory port through
// FETCH / DECODE / EXEC / MEM / WB and parks in TRAP on illegal encodings.
//   clk    : clock
//   reset  : asynchronous active-high reset
//   bus    : multicycle_control_fsm_if.master (IR fields, status, controls)
// Parameter CNT_WIDTH sets the width of the performance counters.
// Optional feature macro CTRL_PERF_CNT_EN: when defined, cycle_count and
// instret_count are live counters; otherwise both outputs are tied to 0.
// ---------------------------------------------------------------------------
module multicycle_control_fsm
    import processor_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    alu_op_e     dec_alu_op;
    logic        dec_illegal;

    logic        is_rtype;
    logic        is_load;
    logic        is_store;
    logic        branch_taken;

    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        alu_src_b;
    alu_op_e     alu_operation;
    logic [1:0]  wb_sel;
    logic        instr_done;
    logic        illegal_instr;

    alu_decoder u_alu_decoder (
        .opcode_i  (bus.opcode),
        .funct3_i  (bus.funct3),
        .funct7_i  (bus.funct7),
        .alu_op_o  (dec_alu_op),
        .illegal_o (dec_illegal)
    );

    assign is_rtype = (bus.opcode == OPC_RTYPE);
    assign is_load  = (bus.opcode == OPC_LOAD);
    assign is_store = (bus.opcode == OPC_STORE);

    // funct3[0] distinguishes BNE from BEQ; other funct3 values never get
    // past DECODE.
    assign branch_taken = bus.funct3[0] ? ~bus.alu_zero : bus.alu_zero;

    // The only state register. Reset is asynchronous so the sequencer
    // restarts from FETCH as soon as reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode. Outputs are a function of the current
    // state and the IR fields; mem_ready only matters in FETCH and MEM.
    // The final reset override makes every enable and request drop the
    // moment reset rises, even mid-cycle, without waiting for the state
    // register to update.
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        reg_write     = 1'b0;
        alu_src_b     = 1'b0;
        alu_operation = ALU_ADD;
        wb_sel        = WB_SEL_ALU;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        // The IR is stable from DECODE until the instruction retires, so
        // the decoded operation can be presented for that whole window.
        if ((state_q != ST_FETCH) && (state_q != ST_TRAP)) begin
            alu_operation = dec_alu_op;
        end

        case (state_q)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b0;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_PLUS4;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                case (bus.opcode)
                    OPC_RTYPE: begin
                        alu_src_b = 1'b0;
                        state_d   = ST_WB;
                    end
                    OPC_IALU, OPC_LUI: begin
                        alu_src_b = 1'b1;
                        state_d   = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        alu_src_b  = 1'b0;
                        pc_write   = branch_taken;
                        pc_src     = branch_taken ? PC_SRC_TARGET : PC_SRC_PLUS4;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OPC_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_TARGET;
                        reg_write  = 1'b1;
                        wb_sel     = WB_SEL_PC4;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                // Keep the address operands steady while memory stalls.
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                alu_src_b    = 1'b1;
                if (bus.mem_ready) begin
                    if (is_store) begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d    = ST_WB;
                    end
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                alu_src_b  = ~is_rtype;
                wb_sel     = is_load ? WB_SEL_MEM : WB_SEL_ALU;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_TRAP: begin
                illegal_instr = 1'b1;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (reset) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    assign bus.mem_req       = mem_req;
    assign bus.mem_we        = mem_we;
    assign bus.mem_addr_sel  = mem_addr_sel;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_src        = pc_src;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_operation = alu_operation;
    assign bus.wb_sel        = wb_sel;
    assign bus.instr_done    = instr_done;
    assign bus.illegal_instr = illegal_instr;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_count_q;
    logic [CNT_WIDTH-1:0] instret_count_q;

    // Performance counters wrap naturally at 2^CNT_WIDTH. They stop in
    // TRAP so the values left behind describe the program up to the fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else if (state_q != ST_TRAP) begin
            cycle_count_q <= cycle_count_q + CNT_WIDTH'(1);
            if (instr_done) begin
                instret_count_q <= instret_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.cycle_count   = cycle_count_q;
    assign bus.instret_count = instret_count_q;
`else
    assign bus.cycle_count   = {CNT_WIDTH{1'b0}};
    assign bus.instret_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Self-checking bench for multicycle_control_fsm: a table of single
// instructions with expected ALU op / legality / latency, hand-written
// corner sequences, and randomized instruction streams compared cycle by
// cycle against a phase-level reference model.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;
    import processor_pkg::*;

    localparam int CW = 32;

`ifdef CTRL_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_WIDTH(CW)) bus ();

    multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checkCount   = 0;
    int failCount    = 0;
    int modelCycles  = 0;
    int modelInstret = 0;

    typedef struct {
        int memReq;
        int memWe;
        int memAddrSel;
        int irWrite;
        int pcWrite;
        int pcSrc;
        int regWrite;
        int aluSrcB;
        int aluOp;
        int wbSel;
        int instrDone;
        int illegal;
    } expOut_t;

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z;
        int         expAluOp;
        int         expIllegal;
        int         expLatency;
    } vec_t;

    // Comparison primitive; every check in the bench goes through here.
    task automatic checkField(input string tag, input string field,
                              input longint got, input longint exp);
        checkCount++;
        if (got != exp) begin
            failCount++;
            $display("[TB] FAIL %s.%s got=%0d exp=%0d", tag, field, got, exp);
        end
    endtask

    function automatic expOut_t blankExp();
        expOut_t e;
        e.memReq = 0; e.memWe = 0; e.memAddrSel = 0; e.irWrite = 0;
        e.pcWrite = 0; e.pcSrc = 0; e.regWrite = 0; e.aluSrcB = -1;
        e.aluOp = -1; e.wbSel = 0; e.instrDone = 0; e.illegal = 0;
        return e;
    endfunction

    // ALU operation straight from the decode table (enum values as ints).
    function automatic int refAluOp(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7);
        int base [8];
        int op;
        base = '{0, 5, 8, 9, 4, 6, 3, 2};
        op = -1;
        if (opc == OPC_RTYPE || opc == OPC_IALU) begin
            op = base[f3];
            if (f3 == 3'd0 && opc == OPC_RTYPE && f7 == 7'b0100000) op = 1;
            if (f3 == 3'd5 && f7[5]) op = 7;
        end else if (opc == OPC_LUI) begin
            op = 10;
        end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
            op = 0;
        end else if (opc == OPC_BRANCH) begin
            op = 1;
        end
        return op;
    endfunction

    function automatic bit refIllegal(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7);
        if (opc == OPC_RTYPE)
            return !(f7 == 7'b0000000 || f7 == 7'b0100000) ||
                   (f7 == 7'b0100000 && !(f3 == 3'd0 || f3 == 3'd5));
        if (opc == OPC_IALU || opc == OPC_LUI || opc == OPC_JAL) return 1'b0;
        if (opc == OPC_BRANCH) return f3 > 3'd1;
        if (opc == OPC_LOAD || opc == OPC_STORE) return f3 != 3'd2;
        return 1'b1;
    endfunction

    // Compare every observable output against one expected record.
    // Mux selects are only meaningful while the enable they steer is set.
    task automatic checkOutput(input expOut_t e, input string tag);
        checkField(tag, "mem_req", bus.mem_req, e.memReq);
        checkField(tag, "mem_we", bus.mem_we, e.memWe);
        if (e.memReq != 0) checkField(tag, "mem_addr_sel", bus.mem_addr_sel, e.memAddrSel);
        checkField(tag, "ir_write", bus.ir_write, e.irWrite);
        checkField(tag, "pc_write", bus.pc_write, e.pcWrite);
        if (e.pcWrite != 0) checkField(tag, "pc_src", bus.pc_src, e.pcSrc);
        checkField(tag, "reg_write", bus.reg_write, e.regWrite);
        if (e.regWrite != 0) checkField(tag, "wb_sel", bus.wb_sel, e.wbSel);
        checkField(tag, "instr_done", bus.instr_done, e.instrDone);
        checkField(tag, "illegal_instr", bus.illegal_instr, e.illegal);
        if (e.aluOp >= 0) checkField(tag, "alu_operation", int'(bus.alu_operation), e.aluOp);
        if (e.aluSrcB >= 0) checkField(tag, "alu_src_b", bus.alu_src_b, e.aluSrcB);
        checkField(tag, "cycle_count", bus.cycle_count, PERF_ON ? modelCycles : 0);
        checkField(tag, "instret_count", bus.instret_count, PERF_ON ? modelInstret : 0);
    endtask

    // One clock: inputs are driven just after a rising edge, outputs are
    // sampled on the falling edge, then the model counters advance.
    task automatic runCycle(input expOut_t e, input string tag, input bit ready);
        bus.mem_ready = ready;
        @(negedge clk);
        checkOutput(e, tag);
        @(posedge clk);
        if (e.illegal == 0) modelCycles++;
        if (e.instrDone != 0) modelInstret++;
        #1;
    endtask

    task automatic applyReset();
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.opcode    = OPC_RTYPE;
        bus.funct3    = 3'd0;
        bus.funct7    = 7'd0;
        #1;
        checkField("reset", "mem_req", bus.mem_req, 0);
        checkField("reset", "mem_we", bus.mem_we, 0);
        checkField("reset", "enables", {bus.ir_write, bus.pc_write, bus.reg_write, bus.instr_done}, 0);
        checkField("reset", "illegal_instr", bus.illegal_instr, 0);
        checkField("reset", "cycle_count", bus.cycle_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b0;
        modelCycles  = 0;
        modelInstret = 0;
    endtask

    function automatic vec_t mkVec(input string n, input logic [6:0] o, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic z, input int op,
                                   input int ill, input int lat);
        vec_t v;
        v.name = n; v.opc = o; v.f3 = f3; v.f7 = f7; v.z = z;
        v.expAluOp = op; v.expIllegal = ill; v.expLatency = lat;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.opcode    = v.opc;
        bus.funct3    = v.f3;
        bus.funct7    = v.f7;
        bus.alu_zero  = v.z;
        bus.mem_ready = 1'b1;
    endtask

    // Reference model: walks one instruction through its phases, building
    // the expected outputs for each cycle from the instruction class.
    // fw/mw are the number of not-ready cycles in FETCH and MEM.
    task automatic runInstr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input int fw, input int mw, input string tag,
                            output int cycles);
        expOut_t e;
        bit ill, isLoad, isStore, isBranch, isJal, taken;
        ill      = refIllegal(opc, f3, f7);
        isLoad   = (opc == OPC_LOAD);
        isStore  = (opc == OPC_STORE);
        isBranch = (opc == OPC_BRANCH);
        isJal    = (opc == OPC_JAL);
        cycles   = 0;
        bus.opcode = opc; bus.funct3 = f3; bus.funct7 = f7; bus.alu_zero = z;

        for (int i = 0; i <= fw; i++) begin
            e = blankExp();
            e.memReq = 1; e.memAddrSel = 0;
            if (i == fw) begin e.irWrite = 1; e.pcWrite = 1; e.pcSrc = 0; end
            runCycle(e, {tag, ".fetch"}, i == fw);
            cycles++;
        end

        e = blankExp();
        runCycle(e, {tag, ".decode"}, 1'($urandom));
        cycles++;

        if (ill) begin
            for (int i = 0; i < 3; i++) begin
                e = blankExp();
                e.illegal = 1;
                runCycle(e, {tag, ".trap"}, 1'($urandom));
                cycles++;
            end
            return;
        end

        e = blankExp();
        e.aluOp = refAluOp(opc, f3, f7);
        if (isBranch) begin
            taken = (f3 == 3'd0) ? z : !z;
            e.aluSrcB = 0; e.pcWrite = taken; e.pcSrc = 1; e.instrDone = 1;
        end else if (isJal) begin
            e.pcWrite = 1; e.pcSrc = 1; e.regWrite = 1; e.wbSel = 2; e.instrDone = 1;
        end else begin
            e.aluSrcB = (opc == OPC_RTYPE) ? 0 : 1;
        end
        runCycle(e, {tag, ".exec"}, 1'($urandom));
        cycles++;
        if (isBranch || isJal) return;

        if (isLoad || isStore) begin
            for (int i = 0; i <= mw; i++) begin
                e = blankExp();
                e.memReq = 1; e.memAddrSel = 1; e.memWe = isStore;
                e.instrDone = (isStore && i == mw) ? 1 : 0;
                runCycle(e, {tag, ".mem"}, i == mw);
                cycles++;
            end
            if (isStore) return;
        end

        e = blankExp();
        e.regWrite = 1; e.wbSel = isLoad ? 1 : 0; e.instrDone = 1;
        runCycle(e, {tag, ".wb"}, 1'($urandom));
        cycles++;
    endtask

    initial begin
        vec_t       vecs [$];
        int         cyc, lat, sawOp;
        bit         sawIll;
        logic [6:0] ops [7];
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;

        vecs.push_back(mkVec("add",   OPC_RTYPE,  3'd0, 7'h00, 1'b0,  0, 0, 4));
        vecs.push_back(mkVec("sub",   OPC_RTYPE,  3'd0, 7'h20, 1'b0,  1, 0, 4));
        vecs.push_back(mkVec("sll",   OPC_RTYPE,  3'd1, 7'h00, 1'b0,  5, 0, 4));
        vecs.push_back(mkVec("slt",   OPC_RTYPE,  3'd2, 7'h00, 1'b0,  8, 0, 4));
        vecs.push_back(mkVec("sltu",  OPC_RTYPE,  3'd3, 7'h00, 1'b0,  9, 0, 4));
        vecs.push_back(mkVec("xor",   OPC_RTYPE,  3'd4, 7'h00, 1'b0,  4, 0, 4));
        vecs.push_back(mkVec("srl",   OPC_RTYPE,  3'd5, 7'h00, 1'b0,  6, 0, 4));
        vecs.push_back(mkVec("sra",   OPC_RTYPE,  3'd5, 7'h20, 1'b0,  7, 0, 4));
        vecs.push_back(mkVec("or",    OPC_RTYPE,  3'd6, 7'h00, 1'b0,  3, 0, 4));
        vecs.push_back(mkVec("and",   OPC_RTYPE,  3'd7, 7'h00, 1'b0,  2, 0, 4));
        vecs.push_back(mkVec("addi",  OPC_IALU,   3'd0, 7'h20, 1'b0,  0, 0, 4));
        vecs.push_back(mkVec("srai",  OPC_IALU,   3'd5, 7'h20, 1'b0,  7, 0, 4));
        vecs.push_back(mkVec("slti",  OPC_IALU,   3'd2, 7'h55, 1'b0,  8, 0, 4));
        vecs.push_back(mkVec("lui",   OPC_LUI,    3'd3, 7'h11, 1'b0, 10, 0, 4));
        vecs.push_back(mkVec("lw",    OPC_LOAD,   3'd2, 7'h00, 1'b0,  0, 0, 5));
        vecs.push_back(mkVec("sw",    OPC_STORE,  3'd2, 7'h00, 1'b0,  0, 0, 4));
        vecs.push_back(mkVec("beq",   OPC_BRANCH, 3'd0, 7'h00, 1'b1,  1, 0, 3));
        vecs.push_back(mkVec("bne",   OPC_BRANCH, 3'd1, 7'h00, 1'b1,  1, 0, 3));
        vecs.push_back(mkVec("jal",   OPC_JAL,    3'd0, 7'h00, 1'b0, -1, 0, 3));
        vecs.push_back(mkVec("ill7f", 7'h7f,      3'd0, 7'h00, 1'b0, -1, 1, 0));
        vecs.push_back(mkVec("illR1", OPC_RTYPE,  3'd1, 7'h20, 1'b0, -1, 1, 0));
        vecs.push_back(mkVec("illR7", OPC_RTYPE,  3'd0, 7'h01, 1'b0, -1, 1, 0));
        vecs.push_back(mkVec("illB2", OPC_BRANCH, 3'd2, 7'h00, 1'b0, -1, 1, 0));
        vecs.push_back(mkVec("illL0", OPC_LOAD,   3'd0, 7'h00, 1'b0, -1, 1, 0));
        vecs.push_back(mkVec("illS1", OPC_STORE,  3'd1, 7'h00, 1'b0, -1, 1, 0));
        vecs.push_back(mkVec("ill00", 7'h00,      3'd0, 7'h00, 1'b0, -1, 1, 0));

        $display("[TB] table vectors");
        foreach (vecs[k]) begin
            applyReset();
            applyStimulus(vecs[k]);
            lat = 0; sawOp = -1; sawIll = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c == 3) begin
                    sawOp  = int'(bus.alu_operation);
                    sawIll = bus.illegal_instr;
                    if (sawIll) checkField(vecs[k].name, "trap_mem_req", bus.mem_req, 0);
                end
                if (bus.instr_done && lat == 0) lat = c;
                @(posedge clk);
                #1;
                if (lat != 0 || sawIll) break;
            end
            checkField(vecs[k].name, "latency", lat, vecs[k].expLatency);
            checkField(vecs[k].name, "illegal", sawIll, vecs[k].expIllegal);
            if (vecs[k].expAluOp >= 0) checkField(vecs[k].name, "alu_op", sawOp, vecs[k].expAluOp);
        end

        $display("[TB] hand sequences");
        applyReset();
        runInstr(OPC_RTYPE, 3'd0, 7'h00, 1'b0, 0, 0, "seqAdd", cyc);
        checkField("seqAdd", "cycles", cyc, 4);
        runInstr(OPC_LOAD, 3'd2, 7'h00, 1'b0, 0, 3, "seqLwWait", cyc);
        checkField("seqLwWait", "cycles", cyc, 8);
        runInstr(OPC_BRANCH, 3'd0, 7'h00, 1'b1, 0, 0, "seqBeq", cyc);
        checkField("seqBeq", "cycles", cyc, 3);
        runInstr(OPC_BRANCH, 3'd1, 7'h00, 1'b1, 0, 0, "seqBne", cyc);
        checkField("seqBne", "cycles", cyc, 3);
        runInstr(OPC_STORE, 3'd2, 7'h00, 1'b0, 2, 1, "seqSwWait", cyc);
        checkField("seqSwWait", "cycles", cyc, 7);

        runInstr(7'h7f, 3'd0, 7'h00, 1'b0, 0, 0, "seqTrap7f", cyc);
        applyReset();
        @(negedge clk);
        checkField("trapCleared", "illegal_instr", bus.illegal_instr, 0);
        checkField("trapCleared", "mem_req", bus.mem_req, 1);
        @(posedge clk); #1;
        applyReset();
        runInstr(OPC_RTYPE, 3'd1, 7'h20, 1'b0, 1, 0, "seqTrapR", cyc);
        applyReset();

        // Reset while a store is stalled in MEM.
        bus.opcode = OPC_STORE; bus.funct3 = 3'd2; bus.funct7 = 7'h00;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkField("swMemWait", "mem_req", bus.mem_req, 1);
        checkField("swMemWait", "mem_we", bus.mem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        checkField("swAsyncReset", "mem_req", bus.mem_req, 0);
        checkField("swAsyncReset", "mem_we", bus.mem_we, 0);
        checkField("swAsyncReset", "reg_write", bus.reg_write, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        modelCycles = 0; modelInstret = 0;
        @(negedge clk);
        checkField("swAfterReset", "mem_req", bus.mem_req, 1);
        checkField("swAfterReset", "mem_addr_sel", bus.mem_addr_sel, 0);
        checkField("swAfterReset", "mem_we", bus.mem_we, 0);
        checkField("swAfterReset", "reg_write", bus.reg_write, 0);
        @(posedge clk); #1;

        // Three zero-wait ADDs from reset: 12 cycles, 3 retirements.
        applyReset();
        for (int i = 0; i < 3; i++) runInstr(OPC_RTYPE, 3'd0, 7'h00, 1'b0, 0, 0, "perfAdd", cyc);
        checkField("perf", "cycle_count", bus.cycle_count, PERF_ON ? 12 : 0);
        checkField("perf", "instret_count", bus.instret_count, PERF_ON ? 3 : 0);

        $display("[TB] random stream");
        ops = '{OPC_RTYPE, OPC_IALU, OPC_LUI, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL};
        applyReset();
        for (int n = 0; n < 80; n++) begin
            cyc = int'($urandom_range(0, 9));
            opc = (cyc < 7) ? ops[cyc] : 7'($urandom);
            f3  = 3'($urandom);
            if ((opc == OPC_LOAD || opc == OPC_STORE) && $urandom_range(0, 3) != 0) f3 = 3'd2;
            if (opc == OPC_BRANCH && $urandom_range(0, 4) != 0) f3 = 3'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0, 1:    f7 = 7'h00;
                2, 3:    f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            runInstr(opc, f3, f7, 1'($urandom), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), "rand", cyc);
            if (refIllegal(opc, f3, f7)) applyReset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I-subset datapath.
- Decodes opcode/funct3/funct7 from the instruction register.
- Steps the shared ALU, register file, PC and single memory port through FETCH/DECODE/EXEC/MEM/WB.
- Raises a sticky trap on unsupported encodings.
- Sits beside the datapath inside the processor top; drives all datapath enables and selects.

Parameters:
CNT_WIDTH, 32, width of optional performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
alu_zero  in  1  ALU result == 0
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write request (store)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_write  out  1  latch instruction and old_pc
pc_write  out  1  PC update enable
pc_src  out  2  0 = PC+4, 1 = old_pc+imm target
reg_write  out  1  register-file write enable
alu_src_b  out  1  0 = rs2, 1 = immediate
alu_operation  out  4  ALU op code (package enum)
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
instr_done  out  1  one-cycle retire pulse
illegal_instr  out  1  sticky trap flag
cycle_count  out  CNT_WIDTH  optional counter
instret_count  out  CNT_WIDTH  optional counter

Behaviour:
Reset and output style
- Reset is asynchronous: state goes to FETCH.
- All enables, mem_req and illegal_instr are forced to 0 while reset is high.
- State is registered; outputs are Moore decode of state plus IR fields. No output is registered.

FETCH
- mem_req=1, mem_addr_sel=0.
- When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- Otherwise stay in FETCH with mem_req held high.

DECODE
- Check legality.
- Illegal encoding: go to TRAP. Otherwise go to EXEC.

EXEC (alu_operation per the decode rules below)
- R-type 0110011: alu_src_b=0, next state WB.
- I-ALU 0010011: alu_src_b=1, next state WB.
- LUI 0110111: PASSB, alu_src_b=1, next state WB.
- LOAD 0000011 / STORE 0100011: ADD, alu_src_b=1, next state MEM.
- BRANCH 1100011: SUB on rs1 and rs2.
  - BEQ (funct3 000): taken when alu_zero=1.
  - BNE (funct3 001): taken when alu_zero=0.
  - Taken: pc_write=1, pc_src=1.
  - Next state FETCH, with instr_done=1.
- JAL 1101111: pc_write=1, pc_src=1, reg_write=1, wb_sel=2, instr_done=1, next state FETCH.

MEM
- mem_req=1, mem_addr_sel=1, mem_we = store.
- Stays in MEM until mem_ready=1.
- Store completion: instr_done=1, next state FETCH.
- Load completion: next state WB.

WB
- reg_write=1; wb_sel = 1 for load, 0 otherwise.
- instr_done=1, next state FETCH.

TRAP
- Absorbing state: illegal_instr=1, no requests, no enables.
- Only reset exits it.

Latency with zero memory wait:
- Branch/JAL: 3 cycles.
- R/I/LUI/STORE: 4 cycles.
- LOAD: 5 cycles.
- Each cycle of mem_ready low adds one cycle.

Other rules
- mem_ready is ignored outside FETCH and MEM.
- Reset mid-request drops mem_req immediately; no partial write enable is produced.

ALU decode
- R-type by funct3:
  - 000: SUB if funct7=0100000, else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7[5]=1, else SRL
  - 110: OR
  - 111: AND
- I-ALU: same table, except funct3 000 is always ADD.

Illegal encodings
- Any opcode not in the list above.
- R-type with funct7 not in {0000000, 0100000}.
- R-type with funct7=0100000 and funct3 not in {000, 101}.
- BRANCH with funct3 not in {000, 001}.
- LOAD/STORE with funct3 != 010.

Optional Feature:
Macro CTRL_PERF_CNT_EN.
- Defined:
  - cycle_count increments every clock while not in reset.
  - instret_count increments on instr_done.
  - Both wrap modulo 2^CNT_WIDTH and are cleared by reset.
  - Both freeze in TRAP.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package processor_pkg:
  - opcode localparams
  - alu_op_e (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10)
  - ctrl_state_e
  - pc_src and wb_sel encodings
- Sub-module alu_decoder: combinational; opcode/funct3/funct7 -> alu_operation and illegal flag.

Test Plan:
- Reset, then ADD (0110011, f3=000, f7=0) with mem_ready=1 -> states FETCH, DECODE, EXEC, WB; reg_write and instr_done high only in cycle 4; alu_operation=0.
- LW with mem_ready low for 3 cycles in MEM -> mem_req=1 and mem_addr_sel=1 for 4 cycles; WB has wb_sel=1; total 8 cycles.
- BEQ with alu_zero=1 -> pc_write=1, pc_src=1 in EXEC; BNE with alu_zero=1 -> no pc_write in EXEC; both retire in 3 cycles.
- opcode 1111111, or R-type f7=0100000 f3=001 -> TRAP after DECODE, illegal_instr=1, mem_req stays 0; reset clears the trap.
- Reset asserted during SW MEM wait -> mem_req/mem_we drop asynchronously; after release, FETCH with mem_req=1 and no reg_write.
- CTRL_PERF_CNT_EN defined, 3 ADDs with zero wait -> cycle_count=12, instret_count=3; undefined -> both read 0.
